// File: rtl/uart_operand_collector_pkg.sv
// Shared definitions for the UART operand collector and its neighbours on the adder datapath.
package uart_operand_collector_pkg;

    localparam int unsigned DEFAULT_OPERAND_WIDTH = 512;

    typedef enum logic [1:0] {
        sRX_A = 2'b00,
        sRX_B = 2'b01,
        sHOLD = 2'b10
    } collectorState_t;

endpackage

// File: rtl/operand_shift_reg.sv
// Byte-wide shift register; the first byte shifted in ends up most significant.
module operand_shift_reg #(
    parameter int unsigned WIDTH = 512
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iLoad,
    input  logic [7:0]       iByte,
    output logic [WIDTH-1:0] oData
);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oData <= '0;
        end else if (iLoad) begin
            oData <= {oData[WIDTH-9:0], iByte};
        end
    end

endmodule

// File: rtl/uart_operand_collector.sv
// Assembles operands A then B from the UART byte stream and offers them to the adder
// with a valid/ready handshake; partial frames are dropped after an inter-byte timeout.
module uart_operand_collector
    import uart_operand_collector_pkg::*;
#(
    parameter int unsigned OPERAND_WIDTH = DEFAULT_OPERAND_WIDTH,
    parameter int unsigned TIMEOUT_CLKS  = 12_500_000
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic [7:0]               iRxByte,
    input  logic                     iRxDone,
    output logic [OPERAND_WIDTH-1:0] oOpA,
    output logic [OPERAND_WIDTH-1:0] oOpB,
    output logic                     oOpValid,
    input  logic                     iOpReady,
    output logic                     oBusy,
    output logic                     oOverrun,
    output logic                     oTimeout
);

    localparam int unsigned BYTES_PER_OP = OPERAND_WIDTH / 8;
    localparam int unsigned BC_W         = $clog2(BYTES_PER_OP);
    localparam int unsigned TO_W         = $clog2(TIMEOUT_CLKS);

    collectorState_t state;
    logic [BC_W-1:0] byteCnt;
    logic [TO_W-1:0] toCnt;

    logic loadA;
    logic loadB;
    logic lastByte;
    logic toTerm;

    assign loadA    = (state == sRX_A) && iRxDone;
    assign loadB    = (state == sRX_B) && iRxDone;
    assign lastByte = (byteCnt == BC_W'(BYTES_PER_OP - 1));
    assign toTerm   = (toCnt == TO_W'(TIMEOUT_CLKS - 1));
    // Between A and B the byte count is 0 but the frame is still partial.
    assign oBusy    = (byteCnt != '0) || (state == sRX_B);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= sRX_A;
            byteCnt  <= '0;
            toCnt    <= '0;
            oOpValid <= 1'b0;
            oOverrun <= 1'b0;
            oTimeout <= 1'b0;
        end else begin
            oOverrun <= (state == sHOLD) && iRxDone;
            oTimeout <= 1'b0;
            case (state)
                sRX_A, sRX_B: begin
                    if (iRxDone) begin
                        // A byte on the terminal count wins over the timeout.
                        toCnt <= '0;
                        if (lastByte) begin
                            byteCnt <= '0;
                            if (state == sRX_A) begin
                                state <= sRX_B;
                            end else begin
                                state    <= sHOLD;
                                oOpValid <= 1'b1;
                            end
                        end else begin
                            byteCnt <= byteCnt + 1'b1;
                        end
                    end else if (oBusy) begin
                        if (toTerm) begin
                            state    <= sRX_A;
                            byteCnt  <= '0;
                            toCnt    <= '0;
                            oTimeout <= 1'b1;
                        end else begin
                            toCnt <= toCnt + 1'b1;
                        end
                    end
                end
                sHOLD: begin
                    if (iOpReady) begin
                        state    <= sRX_A;
                        oOpValid <= 1'b0;
                    end
                end
                default: begin
                    state    <= sRX_A;
                    byteCnt  <= '0;
                    toCnt    <= '0;
                    oOpValid <= 1'b0;
                end
            endcase
        end
    end

    operand_shift_reg #(
        .WIDTH (OPERAND_WIDTH)
    ) uOpA (
        .iClk  (iClk),
        .iRst  (iRst),
        .iLoad (loadA),
        .iByte (iRxByte),
        .oData (oOpA)
    );

    operand_shift_reg #(
        .WIDTH (OPERAND_WIDTH)
    ) uOpB (
        .iClk  (iClk),
        .iRst  (iRst),
        .iLoad (loadB),
        .iByte (iRxByte),
        .oData (oOpB)
    );

endmodule

// File: tb/tb_uart_operand_collector.sv
// Scoreboard bench for uart_operand_collector with a byte-queue reference model.
module tb_uart_operand_collector;

    localparam int unsigned W  = 16;
    localparam int unsigned N  = W / 8;
    localparam int unsigned TO = 50;

    logic         iClk = 1'b0;
    logic         iRst = 1'b1;
    logic [7:0]   iRxByte = 8'h00;
    logic         iRxDone = 1'b0;
    logic         iOpReady = 1'b0;
    logic [W-1:0] oOpA;
    logic [W-1:0] oOpB;
    logic         oOpValid;
    logic         oBusy;
    logic         oOverrun;
    logic         oTimeout;

    uart_operand_collector #(
        .OPERAND_WIDTH (W),
        .TIMEOUT_CLKS  (TO)
    ) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iRxByte  (iRxByte),
        .iRxDone  (iRxDone),
        .oOpA     (oOpA),
        .oOpB     (oOpB),
        .oOpValid (oOpValid),
        .iOpReady (iOpReady),
        .oBusy    (oBusy),
        .oOverrun (oOverrun),
        .oTimeout (oTimeout)
    );

    always #5 iClk = ~iClk;

    int unsigned cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int unsigned  at;
    } pair_t;

    // Expected events, tagged with the clock edge after which they must be visible.
    pair_t       pairQ[$];
    int unsigned ovQ[$];
    int unsigned toQ[$];

    // Reference model: bytes of the partial frame, pending-pair flag, idle run length.
    byte unsigned frame[$];
    bit           holding = 1'b0;
    int unsigned  idle = 0;
    bit           expBusy = 1'b0;

    int unsigned  obsTo = 0;
    int unsigned  obsOv = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void failNow(string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    // Drive one cycle of input and advance the model to the state after the next edge.
    task automatic step(input bit strobe, input byte unsigned b, input bit rdy);
        pair_t p;
        @(posedge iClk);
        #2;
        iRxDone  = strobe;
        iRxByte  = b;
        iOpReady = rdy;
        if (holding) begin
            if (strobe) ovQ.push_back(cyc + 1);
            if (rdy) holding = 1'b0;
        end else if (strobe) begin
            frame.push_back(b);
            idle = 0;
            if (frame.size() == 2 * N) begin
                p.a = '0;
                p.b = '0;
                for (int i = 0; i < int'(N); i++) begin
                    p.a = (p.a << 8) | W'(frame[i]);
                    p.b = (p.b << 8) | W'(frame[N + i]);
                end
                p.at = cyc + 1;
                pairQ.push_back(p);
                holding = 1'b1;
                frame.delete();
            end
        end else if (frame.size() > 0) begin
            idle++;
            if (idle == TO) begin
                frame.delete();
                idle = 0;
                toQ.push_back(cyc + 1);
            end
        end
        expBusy = (frame.size() > 0);
    endtask

    task automatic idleSteps(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy);
    endtask

    task automatic sendBytes(input logic [31:0] bytes, input int n);
        logic [31:0] v;
        v = bytes;
        for (int i = n - 1; i >= 0; i--) step(1'b1, v[i*8 +: 8], 1'b0);
    endtask

    task automatic applyReset(input int n);
        @(posedge iClk);
        #2;
        iRst = 1'b1;
        iRxDone = 1'b0;
        iOpReady = 1'b0;
        frame.delete();
        pairQ.delete();
        ovQ.delete();
        toQ.delete();
        holding = 1'b0;
        idle = 0;
        expBusy = 1'b0;
        for (int i = 0; i < n; i++) @(posedge iClk);
        #2;
        iRst = 1'b0;
    endtask

    logic [W-1:0] heldA;
    logic [W-1:0] heldB;
    bit           prevValid = 1'b0;
    pair_t        got;

    always @(posedge iClk) begin
        #1;
        if (iRst) begin
            check("reset oOpA", oOpA, '0);
            check("reset oOpB", oOpB, '0);
            check("reset oOpValid", oOpValid, 0);
            check("reset oBusy", oBusy, 0);
            check("reset oOverrun", oOverrun, 0);
            check("reset oTimeout", oTimeout, 0);
            prevValid = 1'b0;
        end else begin
            while (pairQ.size() > 0 && pairQ[0].at < cyc) begin
                failNow("missing oOpValid for expected pair");
                void'(pairQ.pop_front());
            end
            while (ovQ.size() > 0 && ovQ[0] < cyc) begin
                failNow("missing oOverrun pulse");
                void'(ovQ.pop_front());
            end
            while (toQ.size() > 0 && toQ[0] < cyc) begin
                failNow("missing oTimeout pulse");
                void'(toQ.pop_front());
            end
            if (oOpValid && !prevValid) begin
                if (pairQ.size() == 0) begin
                    failNow("unexpected oOpValid");
                end else begin
                    got = pairQ.pop_front();
                    check("oOpValid latency", cyc, got.at);
                    check("oOpA", oOpA, got.a);
                    check("oOpB", oOpB, got.b);
                    heldA = got.a;
                    heldB = got.b;
                end
            end else if (oOpValid) begin
                check("oOpA stable in hold", oOpA, heldA);
                check("oOpB stable in hold", oOpB, heldB);
            end
            if (oOverrun) begin
                obsOv++;
                if (ovQ.size() == 0) failNow("unexpected oOverrun");
                else check("oOverrun cycle", cyc, ovQ.pop_front());
            end
            if (oTimeout) begin
                obsTo++;
                if (toQ.size() == 0) failNow("unexpected oTimeout");
                else check("oTimeout cycle", cyc, toQ.pop_front());
            end
            check("oBusy", oBusy, expBusy);
            prevValid = oOpValid;
        end
    end

    int unsigned toBefore;
    int unsigned ovBefore;

    initial begin
        applyReset(3);

        // Scenario 1: pair presented one clock after the last B byte, held with ready low.
        sendBytes(32'h1234ABCD, 4);
        step(1'b0, 8'h00, 1'b0);
        check("s1 oOpValid", oOpValid, 1);
        check("s1 oOpA", oOpA, 16'h1234);
        check("s1 oOpB", oOpB, 16'hABCD);
        idleSteps(20, 1'b0);
        check("s1 oOpA after 20 clks", oOpA, 16'h1234);

        // Scenario 4: byte dropped in hold, then again in the transfer cycle.
        ovBefore = obsOv;
        step(1'b1, 8'h9F, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("s4 oOverrun in hold", oOverrun, 1);
        check("s4 oOpB unchanged", oOpB, 16'hABCD);
        step(1'b1, 8'h9F, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check("s4 oOverrun on transfer", oOverrun, 1);
        check("s2 oOpValid after transfer", oOpValid, 0);
        check("s4 overrun count", obsOv - ovBefore, 2);

        // Scenario 2: next frame after the transfer.
        sendBytes(32'h01020304, 4);
        step(1'b0, 8'h00, 1'b0);
        check("s2 oOpA", oOpA, 16'h0102);
        check("s2 oOpB", oOpB, 16'h0304);
        step(1'b0, 8'h00, 1'b1);

        // Scenario 3: timeout after three bytes, then a clean frame.
        toBefore = obsTo;
        sendBytes(32'h001234AB, 3);
        idleSteps(60, 1'b0);
        check("s3 timeout count", obsTo - toBefore, 1);
        check("s3 oBusy after timeout", oBusy, 0);
        sendBytes(32'h55667788, 4);
        step(1'b0, 8'h00, 1'b0);
        check("s3 oOpA", oOpA, 16'h5566);
        check("s3 oOpB", oOpB, 16'h7788);
        step(1'b0, 8'h00, 1'b1);

        // Scenario 5: byte on the terminal count is accepted, no timeout.
        toBefore = obsTo;
        step(1'b1, 8'hC1, 1'b0);
        idleSteps(int'(TO) - 1, 1'b0);
        step(1'b1, 8'hC2, 1'b0);
        idleSteps(int'(TO) - 1, 1'b0);
        step(1'b1, 8'hC3, 1'b0);
        step(1'b1, 8'hC4, 1'b0);
        idleSteps(2, 1'b0);
        check("s5 no timeout", obsTo - toBefore, 0);
        check("s5 oOpA", oOpA, 16'hC1C2);
        check("s5 oOpB", oOpB, 16'hC3C4);
        step(1'b0, 8'h00, 1'b1);

        // Scenario 6: reset mid-frame, then a fresh frame.
        sendBytes(32'h00A1A2A3, 3);
        applyReset(2);
        sendBytes(32'hEEFF1122, 4);
        step(1'b0, 8'h00, 1'b0);
        check("s6 oOpA", oOpA, 16'hEEFF);
        check("s6 oOpB", oOpB, 16'h1122);
        step(1'b0, 8'h00, 1'b1);

        // Random traffic with occasional long gaps.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 60) == 0) begin
                idleSteps(int'($urandom_range(TO - 3, TO + 5)), $urandom_range(0, 1) == 1);
            end else begin
                step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0);
            end
        end

        idleSteps(5, 1'b1);
        idleSteps(3, 1'b0);
        check("leftover expected pairs", pairQ.size(), 0);
        check("leftover expected overruns", ovQ.size(), 0);
        check("leftover expected timeouts", toQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
